clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Time-set controller for the 12-hour digital clock.
- Turns two synchronized, debounced push-buttons (mode, inc) into the clock's adv_hr / adv_min / clr controls.
- Handles hold-to-repeat, inactivity timeout and digit blinking for the field being set.
- Sits between the button conditioning logic and the clock core; its outputs drive the clock's adv_hr, adv_min and clr inputs and the display blank enables.

Parameters:
- HOLD_TICKS, 500, ticks of continuous inc hold before the first auto-repeat
- RPT_TICKS, 100, ticks between auto-repeats once repeating
- TIMEOUT_TICKS, 10000, ticks with no button activity before returning to RUN
- BLINK_TICKS, 250, ticks per blink half-period

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- tick  in  1  1 kHz single-cycle enable from the prescaler; all timing counts tick cycles
- mode_btn  in  1  level, synchronized and debounced
- inc_btn  in  1  level, synchronized and debounced
- adv_hr  out  1  single-cycle pulse, advance hours
- adv_min  out  1  single-cycle pulse, advance minutes
- clr  out  1  level; high in any set state (freezes the seconds prescaler)
- hr_on  out  1  hour digits visible
- min_on  out  1  minute digits visible
- mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN

Behaviour:
- Reset (rst=0 at a clk edge):
  - state RUN; adv_hr=adv_min=0, clr=0, hr_on=min_on=1.
  - Hold, timeout and blink counters cleared; blink phase=1.
  - Button history registers set to 1, so a button held through reset produces no press.
  - Reset mid-operation aborts any hold or repeat immediately.
- Edge detect: press_m = mode_btn & ~mode_q; press_i = inc_btn & ~inc_q (history registered every clk).
- FSM, on press_m: RUN→SET_HR→SET_MIN→RUN. Encoding 11 unused; it recovers to RUN on the next clk.
- clr = (state != RUN), decoded from the state register.
- Increment, in SET_HR / SET_MIN only:
  - press_i at edge N → adv_hr (or adv_min) high exactly for the cycle following edge N. All outputs are registered; latency is 1 clk.
  - Exactly one pulse per press.
  - In RUN, inc_btn is ignored and both adv outputs stay 0.
- Auto-repeat:
  - While inc_btn stays high in a set state, hold_cnt increments on tick.
  - When hold_cnt reaches HOLD_TICKS: emit one pulse, then a further pulse every RPT_TICKS ticks.
  - Releasing inc_btn clears hold_cnt and the repeat flag.
  - A state change clears both as well.
- Simultaneous press_m and press_i (or a repeat on the same cycle): the mode change wins and no adv pulse is emitted. Hold state is cleared.
- Timeout:
  - to_cnt increments on tick in set states.
  - Cleared by any press, any repeat pulse, or any state change.
  - At TIMEOUT_TICKS the FSM goes to RUN; no adv pulse is issued.
- Blink:
  - In a set state, the phase toggles every BLINK_TICKS ticks.
  - The phase is forced to 1 (visible) and its counter cleared on state entry and on every adv pulse.
  - SET_HR: hr_on=phase, min_on=1. SET_MIN: min_on=phase, hr_on=1. RUN: both 1.
- Widths: counters sized by $clog2 of their limit + 1. No wrap is ever allowed; each counter saturates at its limit until cleared.
- adv_hr and adv_min are never high on the same cycle.

Test Plan:
1. Reset behaviour: hold rst=0 for 3 clks with mode_btn=1 → mode=00, clr=0, hr_on=min_on=1. Release rst with mode_btn still 1 → no state change.
2. Mode cycling and single press: pulse mode_btn 3 times → mode 01, 10, 00; clr high only while 01/10. In SET_HR, one inc press → exactly one adv_hr pulse, 1 clk after the press edge; adv_min stays 0.
3. Hold-to-repeat: in SET_MIN with HOLD_TICKS=5, RPT_TICKS=2, hold inc for 12 ticks → pulses at press, tick 5, 7, 9, 11 (5 total). Release → no further pulses.
4. Timeout: TIMEOUT_TICKS=20, enter SET_HR and stay idle → mode returns to 00 on the clk after the 20th tick, clr drops, no adv pulse. A press at tick 15 postpones the return to tick 35.
5. Simultaneous press: press_m and press_i on the same edge in SET_HR → mode=10, adv_hr=adv_min=0.
6. Blink: BLINK_TICKS=4 in SET_HR → hr_on toggles every 4 ticks and min_on stays 1. An inc press forces hr_on=1 and restarts the 4-tick count.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-set controller for a 12-hour clock: converts mode/inc buttons into
// hour/minute advance pulses, with hold-to-repeat, inactivity timeout and digit blink.
module clock_set_ctrl #(
    parameter int HOLD_TICKS    = 500,
    parameter int RPT_TICKS     = 100,
    parameter int TIMEOUT_TICKS = 10000,
    parameter int BLINK_TICKS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic       adv_hr,
    output logic       adv_min,
    output logic       clr,
    output logic       hr_on,
    output logic       min_on,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        BAD     = 2'b11
    } state_t;

    localparam int HW = $clog2(HOLD_TICKS) + 1;
    localparam int RW = $clog2(RPT_TICKS) + 1;
    localparam int TW = $clog2(TIMEOUT_TICKS) + 1;
    localparam int BW = $clog2(BLINK_TICKS) + 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
    localparam logic [RW-1:0] RPT_LAST  = RW'(RPT_TICKS - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);
    localparam logic [BW-1:0] BL_LAST   = BW'(BLINK_TICKS - 1);

    state_t        state_reg, state_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic          rpt_reg, rpt_next;
    logic [RW-1:0] rcnt_reg, rcnt_next;
    logic [TW-1:0] to_reg, to_next;
    logic [BW-1:0] bcnt_reg, bcnt_next;
    logic          phase_reg, phase_next;
    logic          mode_q_reg, inc_q_reg;
    logic          adv_hr_reg, adv_hr_next;
    logic          adv_min_reg, adv_min_next;

    logic press_m, press_i, held, in_set, rpt_pulse, timeout;

    always_comb begin
        state_next   = state_reg;
        hold_next    = hold_reg;
        rpt_next     = rpt_reg;
        rcnt_next    = rcnt_reg;
        to_next      = to_reg;
        bcnt_next    = bcnt_reg;
        phase_next   = phase_reg;
        adv_hr_next  = 1'b0;
        adv_min_next = 1'b0;
        rpt_pulse    = 1'b0;
        timeout      = 1'b0;

        press_m = mode_btn & ~mode_q_reg;
        press_i = inc_btn & ~inc_q_reg;
        held    = inc_btn & inc_q_reg;
        in_set  = (state_reg == SET_HR) || (state_reg == SET_MIN);

        // Hold phase counts to HOLD_TICKS, then the repeat counter takes over.
        if (in_set && held) begin
            if (tick) begin
                if (!rpt_reg) begin
                    if (hold_reg == HOLD_LAST) begin
                        rpt_pulse = 1'b1;
                        rpt_next  = 1'b1;
                        rcnt_next = '0;
                        hold_next = HOLD_MAX;
                    end else begin
                        hold_next = hold_reg + 1'b1;
                    end
                end else if (rcnt_reg == RPT_LAST) begin
                    rpt_pulse = 1'b1;
                    rcnt_next = '0;
                end else begin
                    rcnt_next = rcnt_reg + 1'b1;
                end
            end
        end else begin
            hold_next = '0;
            rpt_next  = 1'b0;
            rcnt_next = '0;
        end

        if (in_set && tick) begin
            timeout = (to_reg == TO_LAST);
            to_next = to_reg + 1'b1;
            if (bcnt_reg == BL_LAST) begin
                bcnt_next  = '0;
                phase_next = ~phase_reg;
            end else begin
                bcnt_next = bcnt_reg + 1'b1;
            end
        end

        // Mode change outranks increments, which outrank the timeout.
        if (state_reg == BAD || press_m) begin
            state_next = (state_reg == RUN)    ? SET_HR :
                         (state_reg == SET_HR) ? SET_MIN : RUN;
            hold_next  = '0;
            rpt_next   = 1'b0;
            rcnt_next  = '0;
            to_next    = '0;
            bcnt_next  = '0;
            phase_next = 1'b1;
        end else if (in_set && (press_i || rpt_pulse)) begin
            adv_hr_next  = (state_reg == SET_HR);
            adv_min_next = (state_reg == SET_MIN);
            to_next      = '0;
            bcnt_next    = '0;
            phase_next   = 1'b1;
        end else if (timeout || !in_set) begin
            state_next = RUN;
            hold_next  = '0;
            rpt_next   = 1'b0;
            rcnt_next  = '0;
            to_next    = '0;
            bcnt_next  = '0;
            phase_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= RUN;
            hold_reg    <= '0;
            rpt_reg     <= 1'b0;
            rcnt_reg    <= '0;
            to_reg      <= '0;
            bcnt_reg    <= '0;
            phase_reg   <= 1'b1;
            mode_q_reg  <= 1'b1;
            inc_q_reg   <= 1'b1;
            adv_hr_reg  <= 1'b0;
            adv_min_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            rpt_reg     <= rpt_next;
            rcnt_reg    <= rcnt_next;
            to_reg      <= to_next;
            bcnt_reg    <= bcnt_next;
            phase_reg   <= phase_next;
            mode_q_reg  <= mode_btn;
            inc_q_reg   <= inc_btn;
            adv_hr_reg  <= adv_hr_next;
            adv_min_reg <= adv_min_next;
        end
    end

    assign mode    = state_reg;
    assign clr     = (state_reg != RUN);
    assign adv_hr  = adv_hr_reg;
    assign adv_min = adv_min_reg;
    assign hr_on   = (state_reg == SET_HR)  ? phase_reg : 1'b1;
    assign min_on  = (state_reg == SET_MIN) ? phase_reg : 1'b1;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against an event-level model.
module tb_clock_set_ctrl;

    localparam int HOLD    = 5;
    localparam int RPT     = 2;
    localparam int TIMEOUT = 20;
    localparam int BLINK   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       mode_btn = 1'b1;
    logic       inc_btn = 1'b0;
    logic       adv_hr, adv_min, clr, hr_on, min_on;
    logic [1:0] mode;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int cnt_h = 0;
    int cnt_m = 0;

    clock_set_ctrl #(
        .HOLD_TICKS(HOLD), .RPT_TICKS(RPT),
        .TIMEOUT_TICKS(TIMEOUT), .BLINK_TICKS(BLINK)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .adv_hr(adv_hr), .adv_min(adv_min), .clr(clr),
        .hr_on(hr_on), .min_on(min_on), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: unbounded tick counts since the relevant event, outputs derived arithmetically.
    int m_mode = 0;
    int m_hold = 0;
    int m_idle = 0;
    int m_blink = 0;
    bit m_mq = 1'b1, m_iq = 1'b1;
    bit m_adv_h = 1'b0, m_adv_m = 1'b0;

    always @(posedge clk) begin
        bit pm, pi, held, rpt, inset;
        if (!rst) begin
            m_mode = 0; m_hold = 0; m_idle = 0; m_blink = 0;
            m_mq = 1'b1; m_iq = 1'b1; m_adv_h = 1'b0; m_adv_m = 1'b0;
        end else begin
            pm    = mode_btn && !m_mq;
            pi    = inc_btn && !m_iq;
            held  = inc_btn && m_iq;
            inset = (m_mode != 0);
            rpt   = 1'b0;
            m_adv_h = 1'b0;
            m_adv_m = 1'b0;
            if (inset && held) begin
                if (tick) begin
                    m_hold++;
                    if (m_hold >= HOLD && ((m_hold - HOLD) % RPT) == 0) rpt = 1'b1;
                end
            end else begin
                m_hold = 0;
            end
            if (pm) begin
                m_mode = (m_mode + 1) % 3;
                m_hold = 0; m_idle = 0; m_blink = 0;
            end else if (inset && (pi || rpt)) begin
                if (m_mode == 1) m_adv_h = 1'b1; else m_adv_m = 1'b1;
                m_idle = 0; m_blink = 0;
            end else if (inset) begin
                if (tick) begin m_idle++; m_blink++; end
                if (m_idle >= TIMEOUT) begin
                    m_mode = 0; m_hold = 0; m_idle = 0; m_blink = 0;
                end
            end else begin
                m_idle = 0; m_blink = 0;
            end
            m_mq = mode_btn;
            m_iq = inc_btn;
        end
    end

    always @(negedge clk) begin
        bit vis;
        if (chk_en) begin
            vis = ((m_blink / BLINK) % 2) == 0;
            check("mode", {30'd0, mode}, m_mode);
            check("clr", {31'd0, clr}, (m_mode != 0));
            check("adv_hr", {31'd0, adv_hr}, m_adv_h);
            check("adv_min", {31'd0, adv_min}, m_adv_m);
            check("hr_on", {31'd0, hr_on}, (m_mode == 1) ? vis : 1'b1);
            check("min_on", {31'd0, min_on}, (m_mode == 2) ? vis : 1'b1);
            check("adv_excl", {31'd0, adv_hr & adv_min}, 0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (adv_hr) cnt_h++;
        if (adv_min) cnt_m++;
    end

    task automatic cyc(input logic t, input logic m, input logic i);
        @(negedge clk);
        tick = t; mode_btn = m; inc_btn = i;
    endtask

    task automatic ticks(input int n, input logic i);
        repeat (n) begin
            cyc(1'b1, 1'b0, i);
            cyc(1'b0, 1'b0, i);
            cyc(1'b0, 1'b0, i);
        end
    endtask

    task automatic press_mode();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int h0, m0;
        // Reset held with mode_btn high
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_mode", {30'd0, mode}, 0);
        check("rst_clr", {31'd0, clr}, 0);
        check("rst_hr_on", {31'd0, hr_on}, 1);
        check("rst_min_on", {31'd0, min_on}, 1);
        rst = 1'b1;
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        check("rst_release_mode", {30'd0, mode}, 0);
        cyc(1'b0, 1'b0, 1'b0);

        // Mode cycling
        press_mode();
        check("cyc1_mode", {30'd0, mode}, 1);
        check("cyc1_clr", {31'd0, clr}, 1);
        press_mode();
        check("cyc2_mode", {30'd0, mode}, 2);
        check("cyc2_clr", {31'd0, clr}, 1);
        press_mode();
        check("cyc3_mode", {30'd0, mode}, 0);
        check("cyc3_clr", {31'd0, clr}, 0);

        // Single inc press in SET_HR
        press_mode();
        h0 = cnt_h; m0 = cnt_m;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("single_adv_hr", {31'd0, adv_hr}, 1);
        check("single_adv_min", {31'd0, adv_min}, 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("single_adv_hr_after", {31'd0, adv_hr}, 0);
        check("single_cnt_h", cnt_h - h0, 1);
        check("single_cnt_m", cnt_m - m0, 0);

        // Hold-to-repeat in SET_MIN
        press_mode();
        h0 = cnt_h; m0 = cnt_m;
        cyc(1'b0, 1'b0, 1'b1);
        ticks(12, 1'b1);
        check("repeat_cnt_m", cnt_m - m0, 5);
        ticks(5, 1'b0);
        check("repeat_after_release", cnt_m - m0, 5);
        check("repeat_cnt_h", cnt_h - h0, 0);
        check("repeat_mode", {30'd0, mode}, 2);

        // Timeout
        press_mode();
        check("to_run", {30'd0, mode}, 0);
        press_mode();
        h0 = cnt_h; m0 = cnt_m;
        ticks(19, 1'b0);
        check("to_19", {30'd0, mode}, 1);
        ticks(1, 1'b0);
        check("to_20", {30'd0, mode}, 0);
        check("to_20_clr", {31'd0, clr}, 0);
        check("to_no_adv", (cnt_h - h0) + (cnt_m - m0), 0);

        press_mode();
        h0 = cnt_h;
        ticks(14, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        ticks(19, 1'b0);
        check("to_34", {30'd0, mode}, 1);
        ticks(1, 1'b0);
        check("to_35", {30'd0, mode}, 0);
        check("to_press_pulse", cnt_h - h0, 1);

        // Simultaneous mode and inc press
        press_mode();
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("sim_mode", {30'd0, mode}, 2);
        check("sim_adv_hr", {31'd0, adv_hr}, 0);
        check("sim_adv_min", {31'd0, adv_min}, 0);
        press_mode();

        // Blink in SET_HR
        press_mode();
        check("blink_0", {31'd0, hr_on}, 1);
        ticks(3, 1'b0);
        check("blink_3", {31'd0, hr_on}, 1);
        ticks(1, 1'b0);
        check("blink_4", {31'd0, hr_on}, 0);
        check("blink_4_min", {31'd0, min_on}, 1);
        ticks(4, 1'b0);
        check("blink_8", {31'd0, hr_on}, 1);
        ticks(4, 1'b0);
        check("blink_12", {31'd0, hr_on}, 0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("blink_forced", {31'd0, hr_on}, 1);
        ticks(3, 1'b0);
        check("blink_re3", {31'd0, hr_on}, 1);
        ticks(1, 1'b0);
        check("blink_re4", {31'd0, hr_on}, 0);
        press_mode();
        press_mode();

        // Randomized run
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 999) < 2) ? 1'b0 : 1'b1;
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 59) == 0) mode_btn = ~mode_btn;
            if ($urandom_range(0, 24) == 0) inc_btn = ~inc_btn;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
